array_row_copier: RTL

//  Sequential, parametrised successor to the combinational row-assign entity: holds a

---
 rtl/array_copy_pkg.sv | 33 +++
 rtl/array_row_copier_if.sv | 37 +++
 rtl/array_elem_sat_add.sv | 32 +++
 rtl/array_row_copier.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/array_copy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_copy_pkg                                                           |
// | Shared state encoding, element type and saturating-add helper.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package array_copy_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COPY    = 2'd1,
      DONE_ST = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;

   typedef logic signed [DEF_WIDTH-1:0] elem_t;

   // Reference saturating add for any element width up to 62 bits.
   function automatic longint sat_add(input longint a, input longint b, input int width);
      longint s;
      longint hi;
      longint lo;
      s  = a + b;
      hi = (longint'(1) <<< (width - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/array_row_copier_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_row_copier_if                                                      |
// | Command/status bundle and registered array view of the row copier.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface array_row_copier_if #(
   parameter int WIDTH = 16,
   parameter int ROWS  = 4,
   parameter int COLS  = 4
);
   localparam int RW = $clog2(ROWS);

   typedef logic signed [WIDTH-1:0] word_t;

   logic                         load;
   word_t [ROWS-1:0][COLS-1:0]   a;
   logic                         start;
   logic [RW-1:0]                src_row;
   logic [RW-1:0]                dst_row;
   logic                         accum;
   logic                         busy;
   logic                         done;
   logic                         err;
   word_t [ROWS-1:0][COLS-1:0]   xout;

   modport master (
      output load, a, start, src_row, dst_row, accum,
      input  busy, done, err, xout
   );

   modport slave (
      input  load, a, start, src_row, dst_row, accum,
      output busy, done, err, xout
   );
endinterface
`default_nettype wire

// File: rtl/array_elem_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_elem_sat_add                                                       |
// | Signed WIDTH+1-bit add clamped to the WIDTH-bit range.                   |
// | Present only when ARRAY_COPY_ACCUM_EN is defined.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifdef ARRAY_COPY_ACCUM_EN
module array_elem_sat_add #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] sum
);
   localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] w_wide;

   assign w_wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

   // The two top bits disagree only when the true sum left the WIDTH-bit range.
   always_comb begin
      sum = w_wide[WIDTH-1:0];
      if (w_wide[WIDTH] != w_wide[WIDTH-1]) begin
         sum = w_wide[WIDTH] ? C_MIN : C_MAX;
      end
   end
endmodule
`endif
`default_nettype wire

// File: rtl/array_row_copier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | array_row_copier                                                         |
// | Registered ROWS x COLS array with parallel load and a one-element-per-   |
// | cycle row copy; ARRAY_COPY_ACCUM_EN adds saturating accumulate mode.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module array_row_copier
   import array_copy_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ROWS  = 4,
   parameter int COLS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   array_row_copier_if.slave bus
);
   localparam int              RW       = $clog2(ROWS);
   localparam int              CW       = $clog2(COLS + 1);
   localparam logic [RW:0]     ROWS_LIM = (RW + 1)'(ROWS);
   localparam logic [CW-1:0]   LAST_COL = CW'(COLS - 1);

   typedef logic signed [WIDTH-1:0] word_t;

   word_t [ROWS-1:0][COLS-1:0] r_arr;
   state_t                     r_state;
   logic [CW-1:0]              r_col;
   logic [RW-1:0]              r_src;
   logic [RW-1:0]              r_dst;
   logic                       r_accum;
   logic                       r_busy;
   logic                       r_done;
   logic                       r_err;

   word_t                      w_src_elem;
   word_t                      w_dst_elem;
   word_t                      w_new_elem;
   logic                       w_cmd_bad;

   assign w_cmd_bad = ({1'b0, bus.src_row} >= ROWS_LIM) ||
                      ({1'b0, bus.dst_row} >= ROWS_LIM);

   // Both reads see the array before this cycle's write, so src==dst is safe.
   always_comb begin
      w_src_elem = '0;
      w_dst_elem = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r_col == CW'(c)) begin
               if (r_src == RW'(r)) w_src_elem = r_arr[r][c];
               if (r_dst == RW'(r)) w_dst_elem = r_arr[r][c];
            end
         end
      end
   end

`ifdef ARRAY_COPY_ACCUM_EN
   word_t w_sum;

   array_elem_sat_add #(
      .WIDTH (WIDTH)
   ) u_sat_add (
      .a   (w_dst_elem),
      .b   (w_src_elem),
      .sum (w_sum)
   );

   assign w_new_elem = r_accum ? w_sum : w_src_elem;
`else
   logic unused_accum_path;

   assign w_new_elem        = w_src_elem;
   assign unused_accum_path = ^{r_accum, w_dst_elem};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_arr   <= '0;
         r_col   <= '0;
         r_src   <= '0;
         r_dst   <= '0;
         r_accum <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.load) begin
                  r_arr <= bus.a;
               end else if (bus.start) begin
                  if (w_cmd_bad) begin
                     r_err <= 1'b1;
                  end else begin
                     r_src   <= bus.src_row;
                     r_dst   <= bus.dst_row;
                     r_accum <= bus.accum;
                     r_col   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= COPY;
                  end
               end
            end
            COPY: begin
               for (int r = 0; r < ROWS; r++) begin
                  for (int c = 0; c < COLS; c++) begin
                     if (r_dst == RW'(r) && r_col == CW'(c)) begin
                        r_arr[r][c] <= w_new_elem;
                     end
                  end
               end
               if (r_col == LAST_COL) begin
                  r_col   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE_ST;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            DONE_ST: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.xout = r_arr;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.err  = r_err;

endmodule
`default_nettype wire
